icache_fetch_unit: RTL and testbench
====================================

Name: icache_fetch_unit

Overview:
- Direct-mapped instruction cache between the instruction-fetch stage and the memory adapter's insfetch port.
- Hits return the instruction word in 1 cycle.
- Misses issue a one-cycle try_start_insfetch_task pulse, wait for insfetch_task_done, fill the line, then respond.
- Handles RV32C: a line stores the word exactly as the adapter returns it, with the upper 16 bits zero for compressed instructions.

Parameters:
- INDEX_BITS, 6, line count = 2^INDEX_BITS; index = pc[INDEX_BITS:1], tag = pc[31:INDEX_BITS+1].

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global ready; low freezes all state, outputs hold
- flush_pipline  in  1  abort in-flight request/miss
- fence_i  in  1  invalidate all lines
- req_valid  in  1  fetch request valid
- req_pc  in  32  fetch address, bit0 ignored
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- resp_valid  out  1  one-cycle pulse, response valid
- resp_pc  out  32  pc of response
- resp_ins  out  32  instruction word
- try_start_insfetch_task  out  1  miss launch pulse to adapter
- insfetch_addr  out  32  miss address
- insfetch_task_done  in  1  adapter completion
- insfetch_ins_full  in  32  adapter data, valid when done

Behaviour:
- Reset (rst_n_in==0 at posedge): state=IDLE, all valid bits 0. resp_valid=0, try_start_insfetch_task=0, req_ready=0 during reset. resp_pc, resp_ins and insfetch_addr are 0.
- Storage: valid[2^INDEX_BITS], tag[2^INDEX_BITS] of 31-INDEX_BITS bits, data[2^INDEX_BITS] x 32.
- States: IDLE, ISSUE, WAIT.
- req_ready = (state==IDLE) && !flush_pipline && !fence_i.
- IDLE, request accepted, hit (valid[idx] && tag match):
  - next cycle resp_valid=1, resp_pc=req_pc, resp_ins=data[idx].
  - Back-to-back hits sustain 1 response per cycle.
- IDLE, request accepted, miss:
  - latch pc; next state ISSUE.
- ISSUE:
  - try_start_insfetch_task=1 for exactly this cycle; insfetch_addr=latched pc (held stable in ISSUE and WAIT).
  - next state WAIT.
- WAIT:
  - on insfetch_task_done: write valid=1, tag and data=insfetch_ins_full into the line.
  - Next cycle: resp_valid=1, resp_ins=that word, resp_pc=latched pc; state=IDLE.
  - req_ready stays 0 in the done cycle.
- Miss latency: accept at cycle T, pulse at T+1, done at T+1+N, response at T+2+N.
- flush_pipline (any state): state=IDLE, no response next cycle, a pending response is suppressed. A done arriving in the same cycle is discarded (no fill). Cache contents are kept.
- fence_i:
  - In IDLE: all valid bits cleared next cycle.
  - In ISSUE/WAIT: invalidation applied; the miss completes and its fill is still written.
- fence_i and a fill in the same cycle: the fill line ends valid, all others invalid.
- Index wrap: pc 0x0000_0000 and 0x0000_0080 (INDEX_BITS=6) alias to index 0; the later fill replaces the earlier.
- rdy_in==0: no state, storage or output register changes. try_start is only pulsed in a cycle with rdy_in==1.
- No self-modifying-code coherence beyond fence_i.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined: adds outputs hit_count[31:0] and miss_count[31:0]. Each increments once per accepted request classified as hit or miss. Both wrap at 2^32, reset to 0, hold when rdy_in==0, and are unaffected by flush.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, req pc=0x0000_1000; adapter done 6 cycles after pulse with 0x0010_0093.
  - Required: one pulse with insfetch_addr=0x1000; resp_valid with resp_ins=0x0010_0093 one cycle after done.
- Hit streak:
  - Stimulus: refetch 0x1000, then 3 pre-filled consecutive pcs.
  - Required: no try_start; resp_valid 4 consecutive cycles.
- Compressed:
  - Stimulus: miss returns 0x0000_4501.
  - Required: stored and returned as 0x0000_4501; re-hit returns the same value.
- Flush mid-miss:
  - Stimulus: flush in WAIT, done asserted in the same cycle.
  - Required: no resp_valid; a following req to the same pc misses again.
- Alias/fence:
  - Stimulus: fill 0x0000_0000, then fill 0x0000_0080, then request 0x0000_0000.
  - Required: miss.
  - Stimulus: fence_i in IDLE, then request 0x0080.
  - Required: miss.
- Reset/rdy:
  - Stimulus: rst_n_in low during WAIT.
  - Required: state IDLE, all lines invalid.
  - Stimulus: rdy_in low for 3 cycles during ISSUE.
  - Required: a single pulse is emitted once rdy_in returns high.

Source files
------------

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache sitting between instruction fetch and the memory adapter's insfetch port.
// Optional hit/miss statistics counters are compiled in when ICACHE_STATS_EN is defined.
module icache_fetch_unit #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        fence_i,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_pc,
    output logic [31:0] resp_ins,
    output logic        try_start_insfetch_task,
    output logic [31:0] insfetch_addr,
    input  logic        insfetch_task_done,
    input  logic [31:0] insfetch_ins_full
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 31 - INDEX_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // Even parity over a stored word and its tag; a corrupted line is treated as a miss.
    function automatic logic calc_parity(input logic [31:0] word, input logic [TAG_W-1:0] tag);
        calc_parity = ^{word, tag};
    endfunction

    state_e             state_r;
    state_e             state_s;
    logic [LINES-1:0]   valid_r;
    logic [LINES-1:0]   valid_s;
    logic [LINES-1:0]   fill_mask_s;
    logic [TAG_W-1:0]   tag_mem_r  [LINES];
    logic [31:0]        data_mem_r [LINES];
    logic               par_mem_r  [LINES];
    logic [31:0]        miss_pc_r;
    logic               resp_valid_r;
    logic               resp_valid_s;
    logic [31:0]        resp_pc_r;
    logic [31:0]        resp_pc_s;
    logic [31:0]        resp_ins_r;
    logic [31:0]        resp_ins_s;
    logic               try_start_r;
    logic [INDEX_BITS-1:0] req_idx_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic [INDEX_BITS-1:0] miss_idx_s;
    logic [TAG_W-1:0]   miss_tag_s;
    logic               req_ready_s;
    logic               accept_s;
    logic               hit_s;
    logic               fill_s;

    // Address split, hit detection and handshake qualifiers.
    always_comb begin
        req_idx_s   = req_pc[INDEX_BITS:1];
        req_tag_s   = req_pc[31:INDEX_BITS+1];
        miss_idx_s  = miss_pc_r[INDEX_BITS:1];
        miss_tag_s  = miss_pc_r[31:INDEX_BITS+1];
        req_ready_s = rst_n_in && rdy_in && (state_r == ST_IDLE) && !flush_pipline && !fence_i;
        accept_s    = req_valid && req_ready_s;
        hit_s       = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s) &&
                      (par_mem_r[req_idx_s] == calc_parity(data_mem_r[req_idx_s], req_tag_s));
        fill_s      = rst_n_in && (state_r == ST_WAIT) && insfetch_task_done && !flush_pipline;
    end

    // Miss sequencer next state; flush always returns to idle.
    always_comb begin
        state_s = state_r;
        if (flush_pipline) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !hit_s) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: state_s = ST_WAIT;
                ST_WAIT: begin
                    if (fill_s) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Valid-bit update: fence clears everything, a same-cycle fill survives it.
    always_comb begin
        fill_mask_s = fill_s ? ({{(LINES-1){1'b0}}, 1'b1} << miss_idx_s) : {LINES{1'b0}};
        valid_s     = (fence_i ? {LINES{1'b0}} : valid_r) | fill_mask_s;
    end

    // Response source select: hit data, fresh fill data, or hold.
    always_comb begin
        resp_valid_s = 1'b0;
        resp_pc_s    = resp_pc_r;
        resp_ins_s   = resp_ins_r;
        if (accept_s && hit_s) begin
            resp_valid_s = 1'b1;
            resp_pc_s    = req_pc;
            resp_ins_s   = data_mem_r[req_idx_s];
        end else if (fill_s) begin
            resp_valid_s = 1'b1;
            resp_pc_s    = miss_pc_r;
            resp_ins_s   = insfetch_ins_full;
        end else begin
            resp_valid_s = 1'b0;
        end
    end

    // Control and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r      <= ST_IDLE;
            valid_r      <= {LINES{1'b0}};
            miss_pc_r    <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_pc_r    <= 32'h0000_0000;
            resp_ins_r   <= 32'h0000_0000;
            try_start_r  <= 1'b0;
        end else if (rdy_in) begin
            state_r      <= state_s;
            valid_r      <= valid_s;
            resp_valid_r <= resp_valid_s;
            resp_pc_r    <= resp_pc_s;
            resp_ins_r   <= resp_ins_s;
            try_start_r  <= (state_s == ST_ISSUE);
            if (accept_s && !hit_s) begin
                miss_pc_r <= req_pc;
            end
        end
    end

    // Line storage write on fill (no reset needed: guarded by valid bits).
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill_s) begin
            tag_mem_r[miss_idx_s]  <= miss_tag_s;
            data_mem_r[miss_idx_s] <= insfetch_ins_full;
            par_mem_r[miss_idx_s]  <= calc_parity(insfetch_ins_full, miss_tag_s);
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;

    // Accepted-request classification counters, free-running with wrap.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
        end else if (rdy_in) begin
            if (accept_s && hit_s) begin
                hit_count_r <= hit_count_r + 32'd1;
            end
            if (accept_s && !hit_s) begin
                miss_count_r <= miss_count_r + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_r;
    assign miss_count = miss_count_r;
`endif

    // The launch pulse is withheld while the pipeline is stalled.
    assign try_start_insfetch_task = try_start_r && rdy_in;
    assign req_ready               = req_ready_s;
    assign resp_valid              = resp_valid_r;
    assign resp_pc                 = resp_pc_r;
    assign resp_ins                = resp_ins_r;
    assign insfetch_addr           = miss_pc_r;

endmodule

// File: tb/tb_icache_fetch_unit.sv
// Self-checking bench for icache_fetch_unit: cycle model of the cache contents plus directed scenarios.
module tb_icache_fetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_n_in, rdy_in, flush_pipline, fence_i, req_valid;
    logic [31:0] req_pc;
    logic        req_ready, resp_valid, try_start_insfetch_task, insfetch_task_done;
    logic [31:0] resp_pc, resp_ins, insfetch_addr, insfetch_ins_full;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk_in = ~clk_in;

    icache_fetch_unit #(.INDEX_BITS(6)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .flush_pipline(flush_pipline), .fence_i(fence_i),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_pc(resp_pc), .resp_ins(resp_ins),
        .try_start_insfetch_task(try_start_insfetch_task), .insfetch_addr(insfetch_addr),
        .insfetch_task_done(insfetch_task_done), .insfetch_ins_full(insfetch_ins_full)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: cache contents as arrays, a miss as "outstanding" + "launched".
    bit          mv [64];
    logic [31:0] mt [64];
    logic [31:0] md [64];
    bit          m_busy, m_launched;
    logic [31:0] m_pc;
    bit          e_rv, e_try;
    logic [31:0] e_pc, e_ins;
    int          e_hits, e_miss;

    initial begin
        int  line;
        bit  fill;
        m_busy = 0; m_launched = 0; m_pc = 0; e_rv = 0; e_try = 0; e_pc = 0; e_ins = 0;
        e_hits = 0; e_miss = 0;
        forever begin
            @(posedge clk_in);
            cycle++;
            if (!rst_n_in) begin
                for (int i = 0; i < 64; i++) mv[i] = 0;
                m_busy = 0; m_launched = 0; m_pc = 0;
                e_rv = 0; e_try = 0; e_pc = 0; e_ins = 0; e_hits = 0; e_miss = 0;
            end else if (rdy_in) begin
                e_rv = 0; e_try = 0;
                fill = !flush_pipline && m_busy && m_launched && insfetch_task_done;
                if (!flush_pipline && !m_busy && !fence_i && req_valid) begin
                    line = (req_pc / 2) % 64;
                    if (mv[line] && mt[line] == req_pc / 128) begin
                        e_rv = 1; e_pc = req_pc; e_ins = md[line]; e_hits++;
                    end else begin
                        m_busy = 1; m_launched = 0; m_pc = req_pc; e_try = 1; e_miss++;
                    end
                end else if (!flush_pipline && m_busy && !m_launched) begin
                    m_launched = 1;
                end
                if (fence_i) for (int i = 0; i < 64; i++) mv[i] = 0;
                if (fill) begin
                    line = (m_pc / 2) % 64;
                    mv[line] = 1; mt[line] = m_pc / 128; md[line] = insfetch_ins_full;
                    e_rv = 1; e_pc = m_pc; e_ins = insfetch_ins_full; m_busy = 0;
                end
                if (flush_pipline) m_busy = 0;
            end
        end
    end

    // Per-cycle compare and event monitor, sampled mid-cycle.
    int          pulse_cnt = 0, resp_cnt = 0, pulse_cyc = 0, last_resp_cyc = 0, done_cyc = 0;
    logic [31:0] pulse_addr = 0, last_resp_ins = 0, last_resp_pc = 0;

    initial begin
        @(posedge clk_in);
        forever begin
            @(negedge clk_in);
            #1;
            check("req_ready", req_ready, rst_n_in && rdy_in && !m_busy && !flush_pipline && !fence_i);
            check("resp_valid", resp_valid, e_rv);
            check("try_start", try_start_insfetch_task, e_try && rdy_in);
            if (e_rv || !rst_n_in) begin
                check("resp_pc", resp_pc, e_pc);
                check("resp_ins", resp_ins, e_ins);
            end
            if (m_busy || !rst_n_in) check("insfetch_addr", insfetch_addr, m_pc);
`ifdef ICACHE_STATS_EN
            check("hit_count", hit_count, e_hits);
            check("miss_count", miss_count, e_miss);
`endif
            if (try_start_insfetch_task) begin
                pulse_cnt++; pulse_addr = insfetch_addr; pulse_cyc = cycle;
            end
            if (resp_valid) begin
                resp_cnt++; last_resp_ins = resp_ins; last_resp_pc = resp_pc; last_resp_cyc = cycle;
            end
        end
    end

    task automatic issue(input logic [31:0] pc);
        int n = 0;
        @(negedge clk_in);
        req_valid = 1'b1; req_pc = pc;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk_in); #1; n++;
        end
        check("issue_accepted", req_ready, 1'b1);
        @(negedge clk_in);
        req_valid = 1'b0;
    endtask

    task automatic serve(input int n, input logic [31:0] data, input bit with_flush);
        int k = 0;
        #1;
        while (!try_start_insfetch_task && k < 50) begin
            @(negedge clk_in); #1; k++;
        end
        check("pulse_seen", try_start_insfetch_task, 1'b1);
        repeat (n) @(negedge clk_in);
        insfetch_task_done = 1'b1; insfetch_ins_full = data; flush_pipline = with_flush;
        done_cyc = cycle;
        @(negedge clk_in);
        insfetch_task_done = 1'b0; insfetch_ins_full = 32'h0; flush_pipline = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic miss(input logic [31:0] pc, input logic [31:0] data);
        issue(pc);
        serve(2, data, 1'b0);
    endtask

    initial begin
        int          p0, r0, c0;
        logic [31:0] pcs [4];
        rst_n_in = 0; rdy_in = 1; flush_pipline = 0; fence_i = 0; req_valid = 0; req_pc = 0;
        insfetch_task_done = 0; insfetch_ins_full = 0;
        repeat (3) @(negedge clk_in);
        #1;
        check("ready_in_reset", req_ready, 1'b0);
        check("resp_valid_reset", resp_valid, 1'b0);
        rst_n_in = 1;

        // Cold miss
        p0 = pulse_cnt;
        issue(32'h0000_1000);
        serve(6, 32'h0010_0093, 1'b0);
        check("cold_pulses", pulse_cnt - p0, 32'd1);
        check("cold_addr", pulse_addr, 32'h0000_1000);
        check("cold_ins", last_resp_ins, 32'h0010_0093);
        check("cold_pc", last_resp_pc, 32'h0000_1000);
        check("cold_latency", last_resp_cyc - done_cyc, 32'd1);

        // Hit streak
        miss(32'h0000_1004, 32'h0020_0113);
        miss(32'h0000_1008, 32'h0030_0193);
        miss(32'h0000_100C, 32'h0040_0213);
        pcs[0] = 32'h0000_1000; pcs[1] = 32'h0000_1004; pcs[2] = 32'h0000_1008; pcs[3] = 32'h0000_100C;
        p0 = pulse_cnt; r0 = resp_cnt;
        @(negedge clk_in);
        c0 = cycle;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk_in);
            req_valid = 1'b1; req_pc = pcs[i];
        end
        @(negedge clk_in);
        req_valid = 1'b0;
        @(negedge clk_in);
        check("streak_resps", resp_cnt - r0, 32'd4);
        check("streak_pulses", pulse_cnt - p0, 32'd0);
        check("streak_last_cyc", last_resp_cyc - c0, 32'd4);
        check("streak_last_ins", last_resp_ins, 32'h0040_0213);

        // Compressed instruction
        issue(32'h0000_2002);
        serve(3, 32'h0000_4501, 1'b0);
        check("rvc_fill", last_resp_ins, 32'h0000_4501);
        p0 = pulse_cnt;
        issue(32'h0000_2002);
        @(negedge clk_in);
        check("rvc_hit", last_resp_ins, 32'h0000_4501);
        check("rvc_hit_pulses", pulse_cnt - p0, 32'd0);

        // Flush mid-miss with coincident done
        r0 = resp_cnt;
        issue(32'h0000_3000);
        serve(4, 32'hDEAD_BEEF, 1'b1);
        repeat (2) @(negedge clk_in);
        check("flush_no_resp", resp_cnt - r0, 32'd0);
        p0 = pulse_cnt;
        issue(32'h0000_3000);
        serve(2, 32'h0050_0293, 1'b0);
        check("flush_remiss", pulse_cnt - p0, 32'd1);
        check("flush_refill", last_resp_ins, 32'h0050_0293);

        // Index alias
        miss(32'h0000_0000, 32'h1111_1111);
        miss(32'h0000_0080, 32'h2222_2222);
        p0 = pulse_cnt;
        miss(32'h0000_0000, 32'h1111_1111);
        check("alias_miss", pulse_cnt - p0, 32'd1);

        // fence_i in idle
        @(negedge clk_in); fence_i = 1'b1;
        @(negedge clk_in); fence_i = 1'b0;
        p0 = pulse_cnt;
        miss(32'h0000_0000, 32'h1111_1111);
        check("fence_miss0", pulse_cnt - p0, 32'd1);
        p0 = pulse_cnt;
        miss(32'h0000_0080, 32'h2222_2222);
        check("fence_miss80", pulse_cnt - p0, 32'd1);

        // Reset in WAIT
        issue(32'h0000_4000);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        p0 = pulse_cnt;
        miss(32'h0000_1000, 32'h0010_0093);
        check("reset_invalidates", pulse_cnt - p0, 32'd1);

        // rdy_in low during ISSUE
        p0 = pulse_cnt;
        issue(32'h0000_5000);
        rdy_in = 1'b0;
        #1;
        check("stall_no_pulse", try_start_insfetch_task, 1'b0);
        repeat (3) @(negedge clk_in);
        rdy_in = 1'b1;
        serve(2, 32'h0060_0313, 1'b0);
        check("stall_single_pulse", pulse_cnt - p0, 32'd1);
        check("stall_ins", last_resp_ins, 32'h0060_0313);

        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
        $fatal(1);
    end

endmodule
